nibble_cmp_seq: RTL and testbench

Sequencing controller that performs a WIDTH-bit unsigned magnitude comparison by stepping one 4-bit comparator slice across the operands, most-significant nibble first, with early termination on the first unequal nibble. Each slice evaluation is a 74x85-style 4-bit comparison with cascade inputs; the controller owns operand capture, nibble selection, and cascade seeding. It also owns result hand-off, so one small comparator serves arbitrarily wide operands. It sits between an operand producer and a result consumer through valid/ready handshakes on both sides.

---
 rtl/nibble_cmp_seq.sv | 142 ++++++++++++++
 tb/tb_nibble_cmp_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nibble_cmp_seq.sv
// Wide unsigned magnitude comparator built from one 4-bit slice stepped MSB-first,
// with early exit on the first unequal nibble and valid/ready handshakes on both sides.
module nibble_cmp_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cas_gt,
   input  logic             cas_eq,
   input  logic             cas_lt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [$clog2(WIDTH/4):0] nib_used
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int NUW = $clog2(NIB) + 1;
   localparam logic [IW-1:0]  IDX_TOP = IW'(NIB - 1);
   localparam logic [IW-1:0]  IDX_ONE = IW'(1);
   localparam logic [NUW-1:0] CNT_ONE = NUW'(1);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             cas_gt_q, cas_gt_d, cas_eq_q, cas_eq_d, cas_lt_q, cas_lt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [NUW-1:0]   cnt_q, cnt_d;
   logic [NUW-1:0]   nib_used_q, nib_used_d;
   logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
   logic [3:0]       nib_a, nib_b;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      cas_gt_d   = cas_gt_q;
      cas_eq_d   = cas_eq_q;
      cas_lt_d   = cas_lt_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      nib_used_d = nib_used_q;
      gt_d       = gt_q;
      eq_d       = eq_q;
      lt_d       = lt_q;
      nib_a      = a_q[{idx_q, 2'b00} +: 4];
      nib_b      = b_q[{idx_q, 2'b00} +: 4];

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               cas_gt_d = cas_gt;
               cas_eq_d = cas_eq;
               cas_lt_d = cas_lt;
               idx_d    = IDX_TOP;
               cnt_d    = '0;
               state_d  = CMP;
            end
         end
         CMP: begin
            cnt_d      = cnt_q + CNT_ONE;
            nib_used_d = cnt_q + CNT_ONE;
            if (nib_a > nib_b) begin
               gt_d    = 1'b1;
               state_d = DONE;
            end else if (nib_a < nib_b) begin
               lt_d    = 1'b1;
               state_d = DONE;
            end else if (idx_q != '0) begin
               idx_d = idx_q - IDX_ONE;
            end else begin
               // Cascade priority eq > gt > lt; all-zero cascade still reports equal
               if (cas_eq_q || (!cas_gt_q && !cas_lt_q)) begin
                  eq_d = 1'b1;
               end else if (cas_gt_q) begin
                  gt_d = 1'b1;
               end else begin
                  lt_d = 1'b1;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               gt_d    = 1'b0;
               eq_d    = 1'b0;
               lt_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         cas_gt_q   <= 1'b0;
         cas_eq_q   <= 1'b0;
         cas_lt_q   <= 1'b0;
         idx_q      <= IDX_TOP;
         cnt_q      <= '0;
         nib_used_q <= '0;
         gt_q       <= 1'b0;
         eq_q       <= 1'b0;
         lt_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cas_gt_q   <= cas_gt_d;
         cas_eq_q   <= cas_eq_d;
         cas_lt_q   <= cas_lt_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         nib_used_q <= nib_used_d;
         gt_q       <= gt_d;
         eq_q       <= eq_d;
         lt_q       <= lt_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign gt        = gt_q;
   assign eq        = eq_q;
   assign lt        = lt_q;
   assign nib_used  = nib_used_q;

endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Self-checking bench for nibble_cmp_seq (WIDTH=16): directed vector table
// plus hand-written backpressure, no-bypass and mid-operation reset sequences.
module tb_nibble_cmp_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cas_gt = 1'b0;
   logic        cas_eq = 1'b0;
   logic        cas_lt = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        gt, eq, lt;
   logic [2:0]  nib_used;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cg, ce, cl;
      logic        eg, ee, el;
      int          en;
   } vec_t;

   vec_t vecs[11];

   nibble_cmp_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
      .cas_gt(cas_gt), .cas_eq(cas_eq), .cas_lt(cas_lt),
      .out_valid(out_valid), .out_ready(out_ready),
      .gt(gt), .eq(eq), .lt(lt),
      .nib_used(nib_used)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitReady();
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
   endtask

   // Accept one pair, scramble the ports, then measure latency and result.
   task automatic applyStimulus(input vec_t v, input bit consume);
      int lat = 0;
      waitReady();
      a = v.a; b = v.b;
      cas_gt = v.cg; cas_eq = v.ce; cas_lt = v.cl;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = ~v.a; b = v.b ^ 16'h5A5A;
      cas_gt = ~v.cg; cas_eq = ~v.ce; cas_lt = ~v.cl;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      checkOutput("latency", lat, v.en);
      checkOutput("gt", gt, v.eg);
      checkOutput("eq", eq, v.ee);
      checkOutput("lt", lt, v.el);
      checkOutput("nib_used", nib_used, v.en);
      checkOutput("in_ready_done", in_ready, 0);
      if (consume) begin
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         checkOutput("out_valid_after", out_valid, 0);
         checkOutput("flags_cleared", {gt, eq, lt}, 0);
         checkOutput("in_ready_after", in_ready, 1);
      end
   endtask

   initial begin
      vecs[0]  = '{16'h1234, 16'h1234, 0, 1, 0, 0, 1, 0, 4};
      vecs[1]  = '{16'h9000, 16'h1FFF, 0, 1, 0, 1, 0, 0, 1};
      vecs[2]  = '{16'h12A0, 16'h12B0, 0, 1, 0, 0, 0, 1, 3};
      vecs[3]  = '{16'hFFFF, 16'hFFFF, 1, 0, 1, 1, 0, 0, 4};
      vecs[4]  = '{16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 1, 0, 4};
      vecs[5]  = '{16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 1, 0, 4};
      vecs[6]  = '{16'hFFFF, 16'hFFFF, 0, 0, 1, 0, 0, 1, 4};
      vecs[7]  = '{16'h0000, 16'h0001, 1, 0, 0, 0, 0, 1, 4};
      vecs[8]  = '{16'h0F00, 16'h0E00, 0, 0, 1, 1, 0, 0, 2};
      vecs[9]  = '{16'hA5A5, 16'hA5A4, 0, 0, 1, 1, 0, 0, 4};
      vecs[10] = '{16'h1FFF, 16'h9000, 1, 0, 0, 0, 0, 1, 1};

      // Reset state
      tick();
      checkOutput("rst_in_ready", in_ready, 0);
      tick();
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_flags", {gt, eq, lt}, 0);
      checkOutput("rst_nib_used", nib_used, 0);
      rst = 1'b0;
      #1;
      checkOutput("rst_release_ready", in_ready, 1);

      for (int i = 0; i < 11; i++) applyStimulus(vecs[i], 1'b1);

      // Backpressure with an ignored in_valid pulse, then no-bypass on release
      applyStimulus('{16'h0001, 16'h0002, 0, 1, 0, 0, 0, 1, 4}, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin
            a = 16'h9999; b = 16'h0000; in_valid = 1'b1;
         end
         if (i == 3) in_valid = 1'b0;
         tick();
         checkOutput("bp_out_valid", out_valid, 1);
         checkOutput("bp_lt", {gt, eq, lt}, 1);
         checkOutput("bp_nib_used", nib_used, 4);
         checkOutput("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      in_valid = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid = 1'b0;
      checkOutput("bp_consumed", out_valid, 0);
      checkOutput("bp_idle_ready", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("no_bypass_valid", out_valid, 0);
      end

      // Reset at E2 of an in-flight comparison
      waitReady();
      a = 16'h1234; b = 16'h1235; cas_gt = 0; cas_eq = 1; cas_lt = 0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checkOutput("midrst_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_flags", {gt, eq, lt}, 0);
      checkOutput("midrst_nib_used", nib_used, 0);
      checkOutput("midrst_in_ready_after", in_ready, 1);
      applyStimulus('{16'h0003, 16'h0002, 0, 0, 0, 1, 0, 0, 4}, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
